neural_weight_loader: RTL and testbench

NEURAL_WEIGHT_LOADER -- requirements
Module: neural_weight_loader

---
 rtl/neural_weight_loader_if.sv | 25 ++
 rtl/neural_weight_loader.sv | 73 +++++++
 tb/tb_neural_weight_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/neural_weight_loader_if.sv
// Coefficient-load bus between a word source and the neural weight loader.
// The master drives frame words and START; the slave returns handshake, status and active coefficients.
interface neural_weight_loader_if;
  logic        START;
  logic [16:1] DIN;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic [16:1] cAA;
  logic [16:1] cAB;
  logic [16:1] cBA;
  logic [16:1] cBB;
  logic        LOADED;
  logic        BUSY;
  logic        RESTART_ERR;

  modport master (
    output START, DIN, DIN_VALID,
    input  DIN_READY, cAA, cAB, cBA, cBB, LOADED, BUSY, RESTART_ERR
  );

  modport slave (
    input  START, DIN, DIN_VALID,
    output DIN_READY, cAA, cAB, cBA, cBB, LOADED, BUSY, RESTART_ERR
  );
endinterface

// File: rtl/neural_weight_loader.sv
// Collects a 4-word Q8.8 coefficient frame into shadow registers and commits it
// atomically to the active coefficients driving a two-input neural layer.
module neural_weight_loader (
  input  logic                 CLK,
  input  logic                 RST,
  neural_weight_loader_if.slave bus
);
  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_cnt;
  logic [W:1]   r_shadow [N];
  logic [W:1]   r_coef   [N];
  logic         r_loaded;
  logic         r_restart_err;
  logic         w_accept;

  // START in RECV wins over DIN_VALID, so the restart edge never takes a word
  assign w_accept = (r_state == RECV) && bus.DIN_VALID && !bus.START;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.START) w_state_nxt = RECV;
      RECV:    if (w_accept && (r_cnt == 2'd3)) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word counter, shadow capture, atomic commit and status pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt         <= 2'd0;
      r_loaded      <= 1'b0;
      r_restart_err <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_shadow[i] <= '0;
        r_coef[i]   <= '0;
      end
    end else begin
      r_loaded      <= (r_state == COMMIT);
      r_restart_err <= (r_state == RECV) && bus.START;
      if (((r_state == IDLE) || (r_state == RECV)) && bus.START) begin
        r_cnt <= 2'd0;
      end else if (w_accept) begin
        r_shadow[r_cnt] <= bus.DIN;
        r_cnt           <= r_cnt + 2'd1;
      end
      if (r_state == COMMIT) begin
        for (int i = 0; i < N; i++) r_coef[i] <= r_shadow[i];
      end
    end
  end

  assign bus.DIN_READY   = (r_state == RECV);
  assign bus.BUSY        = (r_state != IDLE);
  assign bus.LOADED      = r_loaded;
  assign bus.RESTART_ERR = r_restart_err;
  assign bus.cAA         = r_coef[0];
  assign bus.cAB         = r_coef[1];
  assign bus.cBA         = r_coef[2];
  assign bus.cBB         = r_coef[3];
endmodule

// File: tb/tb_neural_weight_loader.sv
// Bench for neural_weight_loader: directed frame scenarios plus random traffic,
// checked every cycle against a queue-based frame model.
module tb_neural_weight_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   clk_en = 1'b0;

  neural_weight_loader_if bus ();

  neural_weight_loader dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Frame model: idle / receiving / committing, with a queue of received words
  int          m_phase;
  logic [16:1] m_words [$];
  logic [16:1] m_coef  [4];
  bit          m_loaded;
  bit          m_rerr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_words.delete();
      for (int i = 0; i < 4; i++) m_coef[i] = 16'h0000;
      m_loaded = 0;
      m_rerr   = 0;
    end else begin
      m_loaded = (m_phase == 2);
      m_rerr   = 0;
      if (m_phase == 2) begin
        for (int i = 0; i < 4; i++) m_coef[i] = m_words[i];
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (bus.START) begin
          m_words.delete();
          m_rerr = 1;
        end else if (bus.DIN_VALID) begin
          m_words.push_back(bus.DIN);
          if (m_words.size() == 4) m_phase = 2;
        end
      end else if (bus.START) begin
        m_words.delete();
        m_phase = 1;
      end
    end
  end

  bit cmp_en = 0;
  int loaded_cnt = 0;
  int rerr_cnt   = 0;
  int bad_seen   = 0;

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cAA", 32'(bus.cAA), 32'(m_coef[0]));
      chk("cAB", 32'(bus.cAB), 32'(m_coef[1]));
      chk("cBA", 32'(bus.cBA), 32'(m_coef[2]));
      chk("cBB", 32'(bus.cBB), 32'(m_coef[3]));
      chk("LOADED", 32'(bus.LOADED), 32'(m_loaded));
      chk("RESTART_ERR", 32'(bus.RESTART_ERR), 32'(m_rerr));
      chk("BUSY", 32'(bus.BUSY), 32'(m_phase != 0));
      chk("DIN_READY", 32'(bus.DIN_READY), 32'(m_phase == 1));
      if (bus.LOADED) loaded_cnt++;
      if (bus.RESTART_ERR) rerr_cnt++;
      if (bus.cAA == 16'h1234 || bus.cAB == 16'h1234 || bus.cAA == 16'h5678 ||
          bus.cAB == 16'h5678 || bus.cBA == 16'h9999 || bus.cAA == 16'h9999)
        bad_seen++;
    end
  end

  task automatic cyc(input bit s, input bit v, input logic [16:1] d);
    @(negedge clk);
    bus.START     = s;
    bus.DIN_VALID = v;
    bus.DIN       = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0000);
  endtask

  task automatic chk_coefs(input string name, input logic [16:1] a, input logic [16:1] b,
                           input logic [16:1] c, input logic [16:1] d);
    chk({name, ".cAA"}, 32'(bus.cAA), 32'(a));
    chk({name, ".cAB"}, 32'(bus.cAB), 32'(b));
    chk({name, ".cBA"}, 32'(bus.cBA), 32'(c));
    chk({name, ".cBB"}, 32'(bus.cBB), 32'(d));
  endtask

  int base;

  initial begin
    bus.START = 0; bus.DIN_VALID = 0; bus.DIN = 16'h0000;

    // Reset pulse with no clock edge
    #1 rst = 1;
    #2;
    chk_coefs("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("reset.BUSY", 32'(bus.BUSY), 32'd0);
    chk("reset.DIN_READY", 32'(bus.DIN_READY), 32'd0);
    chk("reset.LOADED", 32'(bus.LOADED), 32'd0);
    rst = 0;
    clk_en = 1;
    cmp_en = 1;
    idle(2);

    // Back-to-back load with exact commit timing
    base = loaded_cnt;
    cyc(1, 0, 16'h0000);
    cyc(0, 1, 16'h0100);
    cyc(0, 1, 16'h0100);
    cyc(0, 1, 16'h0000);
    cyc(0, 1, 16'h0000);
    @(negedge clk);
    bus.DIN_VALID = 0;
    chk_coefs("b2b.before", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("b2b.commit_busy", 32'(bus.BUSY), 32'd1);
    chk("b2b.early_loaded", 32'(bus.LOADED), 32'd0);
    @(negedge clk);
    chk_coefs("b2b.after", 16'h0100, 16'h0100, 16'h0000, 16'h0000);
    chk("b2b.loaded", 32'(bus.LOADED), 32'd1);
    @(negedge clk);
    chk("b2b.loaded_drop", 32'(bus.LOADED), 32'd0);
    idle(2);
    chk("b2b.loaded_count", 32'(loaded_cnt - base), 32'd1);

    // Gapped load, three idle cycles between words
    base = loaded_cnt;
    cyc(1, 0, 16'h0000);
    cyc(0, 1, 16'hFFFF); idle(3);
    cyc(0, 1, 16'hFFFF); idle(3);
    cyc(0, 1, 16'h0100); idle(3);
    chk_coefs("gap.mid", 16'h0100, 16'h0100, 16'h0000, 16'h0000);
    cyc(0, 1, 16'h0100); idle(4);
    chk_coefs("gap.final", 16'hFFFF, 16'hFFFF, 16'h0100, 16'h0100);
    chk("gap.loaded_count", 32'(loaded_cnt - base), 32'd1);

    // Abort by START mid-frame; the restart edge also offers a word that must be dropped
    base = rerr_cnt;
    bad_seen = 0;
    cyc(1, 0, 16'h0000);
    cyc(0, 1, 16'h1234);
    cyc(0, 1, 16'h5678);
    cyc(1, 1, 16'h9999);
    cyc(0, 1, 16'h0100);
    cyc(0, 1, 16'h0100);
    cyc(0, 1, 16'h0100);
    cyc(0, 1, 16'h0100);
    idle(4);
    chk_coefs("abort.final", 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    chk("abort.rerr_count", 32'(rerr_cnt - base), 32'd1);
    chk("abort.stale_visible", 32'(bad_seen), 32'd0);

    // Reset mid-frame after three accepted words
    cyc(1, 0, 16'h0000);
    cyc(0, 1, 16'h1111);
    cyc(0, 1, 16'h2222);
    cyc(0, 1, 16'h3333);
    @(negedge clk);
    bus.DIN_VALID = 0;
    #2 rst = 1;
    #1;
    chk_coefs("midrst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("midrst.BUSY", 32'(bus.BUSY), 32'd0);
    #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 16'h7777);
      chk("midrst.no_ready", 32'(bus.DIN_READY), 32'd0);
    end
    idle(3);
    chk_coefs("midrst.after", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("midrst.idle", 32'(bus.BUSY), 32'd0);

    // START asserted during the COMMIT cycle is ignored
    base = rerr_cnt;
    cyc(1, 0, 16'h0000);
    cyc(0, 1, 16'h0A0B);
    cyc(0, 1, 16'h0C0D);
    cyc(0, 1, 16'hF00E);
    cyc(0, 1, 16'h8000);
    cyc(1, 0, 16'h0000);
    cyc(0, 0, 16'h0000);
    chk("cstart.loaded", 32'(bus.LOADED), 32'd1);
    chk("cstart.idle", 32'(bus.BUSY), 32'd0);
    chk_coefs("cstart", 16'h0A0B, 16'h0C0D, 16'hF00E, 16'h8000);
    idle(2);
    chk("cstart.no_rerr", 32'(rerr_cnt - base), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0), 16'($urandom));
    idle(6);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
